tone_audio_out: RTL and testbench
=================================

Name: tone_audio_out

Overview:
- Consumer side of the game's tone interface. Takes the 32-bit frequency word (Hz) that the sound-effect sequencer produces and synthesises a square wave from it. Drives the on-board audio DAC over a 4-wire I2S-style serial link: mclk, lrck, sck, sdin.
- Sits between the sound-effect sequencer and the top-level audio pins.
- Both stereo channels carry the same mono sample.

Parameters:
- CLK_FREQ, 100_000_000: frequency of clk in Hz. It is the wrap modulus of the phase accumulator.
- SILENCE_MIN, 20000: any tone value at or above this (or 0) means silence.
- AMP_STEP, 16'h0800: sample amplitude per volume step.

Ports:
- clk  in  1  system clock, 100 MHz. The sequencer's slow clock is derived from it, so tone is synchronous to clk.
- rst_n  in  1  reset, asynchronous, active-low.
- tone  in  32  requested frequency in Hz. Silence if 0 or >= SILENCE_MIN.
- volume  in  3  0 = mute, 1..7 = amplitude multiplier.
- audio_mclk  out  1  master clock = clk/4.
- audio_lrck  out  1  frame clock = clk/512. Low = left channel, high = right channel.
- audio_sck  out  1  bit clock = clk/8.
- audio_sdin  out  1  serial sample data, MSB first.

Behaviour:
- Reset: asynchronous on rst_n low. The following are all cleared to 0:
  - clk_cnt (9-bit, free-running)
  - phase accumulator acc (32-bit)
  - square state sq
  - tone_r, vol_r, sample_r (16-bit)
  - audio_sdin
  All clock outputs read 0 during reset.
- Clock generation:
  - clk_cnt increments every clk and wraps 511 -> 0.
  - audio_mclk = clk_cnt[1], audio_sck = clk_cnt[2], audio_lrck = clk_cnt[8].
  - These outputs are bits of a registered counter, so they are glitch-free.
- Input capture: tone_r <= tone and vol_r <= volume every clk (one-cycle latency).
- Square synthesis, evaluated each clk on tone_r:
  - Silent (tone_r == 0 or tone_r >= SILENCE_MIN): acc <= 0, sq <= 0.
  - Otherwise: let nxt = acc + 2*tone_r.
    - If nxt >= CLK_FREQ: acc <= nxt - CLK_FREQ and sq toggles.
    - Else: acc <= nxt.
  - 2*tone_r < 40000, so no overflow in 32 bits.
  - A tone change keeps the accumulator value. Phase is continuous, with no reset of acc.
  - Going from silent to a tone: sq starts at 0, and the first toggle comes after ceil(CLK_FREQ / (2*tone)) clks.
- Sample formation:
  - amp = vol_r * AMP_STEP, 16-bit unsigned; 7 * 0x0800 = 0x3800.
  - Target value = 0 if silent or vol_r == 0.
  - Otherwise target value = +amp if sq == 1, and -amp (two's complement) if sq == 0.
  - sample_r is loaded with this value only on the clk where clk_cnt == 511. The new sample therefore applies from the start of a left frame, and both channels of one frame carry the identical sample.
- Serial framing:
  - One lrck half = 256 clk = 32 sck slots. Slot index s = clk_cnt[7:3].
  - Slot 0: 0 (one-bit I2S delay after the lrck edge).
  - Slots 1..16: sample_r[15] .. sample_r[0].
  - Slots 17..31: 0.
  - audio_sdin is registered. It is updated on the clk where clk_cnt[2:0] == 3'b111 with the bit for the next slot, so it changes coincident with the sck falling edge and is stable across every sck rising edge.
- Simultaneous events: a tone change in the same clk as a toggle uses the old tone_r for that clk.
- Reset mid-frame: all outputs go to 0 immediately. After release, framing restarts at clk_cnt = 0 (left channel, slot 0).

Test Plan:
- Reset and clocks: hold rst_n=0 for 10 clk -> all outputs 0. After release, check the three output clocks:
  - audio_mclk period 4 clk.
  - audio_sck period 8 clk.
  - audio_lrck period 512 clk; it first rises 256 clk after release.
- tone=1000, volume=7: sq toggles exactly every 50000 clk. sample_r alternates between 16'h3800 and 16'hC800 at frame boundaries.
- Silence: tone=20000 (also repeat with tone=0), volume=7 -> sample_r=0, audio_sdin constantly 0, acc=0.
- volume=0 with tone=466 -> sdin always 0. Then volume=1 -> the next frame carries ±16'h0800.
- Serial bit order: with sample_r=16'h3800 held, capture sdin on sck rising edges -> bit sequence 0, then 0011100000000000, then 15 zeros. Same sequence in the right half of the frame.
- Reset mid-operation: assert rst_n during slot 9 of a right half with tone=523 -> outputs 0 within the same clk. After release, the first frame starts left, slot 0, with sample_r=0 until clk_cnt == 511.

Source files
------------

// File: rtl/tone_audio_out.sv
// Square-wave tone synthesiser feeding a 4-wire I2S-style audio DAC link.
// The frequency word is in Hz, and the same mono sample goes out on both stereo channels.
module tone_audio_out #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned SILENCE_MIN = 20000,
  parameter logic [15:0] AMP_STEP    = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tone,
  input  logic [2:0]  volume,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);

  logic [8:0]  clk_cnt_reg;
  logic [31:0] tone_reg;
  logic [2:0]  vol_reg;
  logic [31:0] acc_reg, acc_next, acc_sum;
  logic        sq_reg, sq_next;
  logic [15:0] sample_reg, sample_next, amp;
  logic        sdin_reg, sdin_next;
  logic        silent;
  logic [4:0]  slot_next;
  logic [31:0] slot_bits;

  assign audio_mclk = clk_cnt_reg[1];
  assign audio_sck  = clk_cnt_reg[2];
  assign audio_lrck = clk_cnt_reg[8];
  assign audio_sdin = sdin_reg;

  assign silent  = (tone_reg == 32'd0) || (tone_reg >= SILENCE_MIN);
  // Twice the tone per clk, because a full period is made of two toggles.
  assign acc_sum = acc_reg + {tone_reg[30:0], 1'b0};
  assign amp     = AMP_STEP * {13'd0, vol_reg};

  always_comb begin
    acc_next = acc_reg;
    sq_next  = sq_reg;
    if (silent) begin
      acc_next = 32'd0;
      sq_next  = 1'b0;
    end else if (acc_sum >= CLK_FREQ) begin
      acc_next = acc_sum - CLK_FREQ;
      sq_next  = ~sq_reg;
    end else begin
      acc_next = acc_sum;
    end
  end

  always_comb begin
    sample_next = 16'd0;
    if (!silent && vol_reg != 3'd0)
      sample_next = sq_reg ? amp : (16'd0 - amp);
  end

  // Per-slot bit of one channel half: I2S delay slot, 16 data bits MSB first, then padding.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_slot
      if (gi >= 1 && gi <= 16) begin : g_data
        assign slot_bits[gi] = sample_reg[16-gi];
      end else begin : g_pad
        assign slot_bits[gi] = 1'b0;
      end
    end
  endgenerate

  assign slot_next = clk_cnt_reg[7:3] + 5'd1;
  assign sdin_next = slot_bits[slot_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_reg <= 9'd0;
      tone_reg    <= 32'd0;
      vol_reg     <= 3'd0;
      acc_reg     <= 32'd0;
      sq_reg      <= 1'b0;
      sample_reg  <= 16'd0;
      sdin_reg    <= 1'b0;
    end else begin
      clk_cnt_reg <= clk_cnt_reg + 9'd1;
      tone_reg    <= tone;
      vol_reg     <= volume;
      acc_reg     <= acc_next;
      sq_reg      <= sq_next;
      if (clk_cnt_reg == 9'd511)
        sample_reg <= sample_next;
      if (clk_cnt_reg[2:0] == 3'b111)
        sdin_reg <= sdin_next;
    end
  end

endmodule

// File: tb/tb_tone_audio_out.sv
// Directed-vector bench for tone_audio_out: clocks, silence, volume, tone timing,
// serial bit order and mid-frame reset.
module tb_tone_audio_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tone = 32'd0;
  logic [2:0]  volume = 3'd0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  tone_audio_out dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tone       (tone),
    .volume     (volume),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance n clks; clk_cnt after k clks since release is k mod 512.
  task automatic run(input int n, input bit clk_chk, input bit sdin_zero);
    logic [8:0] c;
    for (int i = 0; i < n; i++) begin
      tick();
      c = cyc[8:0];
      if (clk_chk)
        chk("clocks", {29'd0, audio_lrck, audio_sck, audio_mclk}, {29'd0, c[8], c[2], c[1]});
      if (sdin_zero)
        chk("sdin_zero", {31'd0, audio_sdin}, 32'd0);
    end
  endtask

  task automatic to_frame();
    do tick(); while (cyc % 512 != 0);
  endtask

  // bits[31-s] is the expected sdin value in slot s of each channel half.
  task automatic ser_frame(input string tag, input logic [31:0] bits);
    int s;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (cyc % 8 == 4) begin
        s = (cyc % 256) / 8;
        chk(tag, {31'd0, audio_sdin}, {31'd0, bits[31-s]});
      end
    end
  endtask

  initial begin
    logic [31:0] bits_f800, bits_3800;
    bits_f800 = 32'b0_1111100000000000_000000000000000;
    bits_3800 = 32'b0_0011100000000000_000000000000000;

    // Reset held for 10 clks
    repeat (10) @(posedge clk);
    #1;
    chk("reset_outs", {28'd0, audio_lrck, audio_sck, audio_mclk, audio_sdin}, 32'd0);
    chk("reset_sample", {16'd0, dut.sample_reg}, 32'd0);
    chk("reset_acc", dut.acc_reg, 32'd0);
    chk("reset_sq", {31'd0, dut.sq_reg}, 32'd0);

    // Release and watch the first frame of clocks; lrck rises at clk 256
    rst_n = 1'b1;
    cyc = 0;
    run(255, 1'b1, 1'b1);
    chk("lrck_before_256", {31'd0, audio_lrck}, 32'd0);
    run(1, 1'b1, 1'b1);
    chk("lrck_at_256", {31'd0, audio_lrck}, 32'd1);
    run(256, 1'b1, 1'b1);

    // Volume 0 keeps the output silent despite a valid tone
    tone = 32'd466;
    volume = 3'd0;
    run(1024, 1'b1, 1'b1);
    chk("vol0_sample", {16'd0, dut.sample_reg}, 32'd0);
    volume = 3'd1;
    run(512, 1'b1, 1'b0);
    chk("vol1_sample", {16'd0, dut.sample_reg}, 32'h0000_F800);
    ser_frame("sdin_f800", bits_f800);

    // Silence at tone = SILENCE_MIN and at tone = 0
    tone = 32'd20000;
    volume = 3'd7;
    run(512, 1'b0, 1'b0);
    chk("sil20k_sample", {16'd0, dut.sample_reg}, 32'd0);
    chk("sil20k_acc", dut.acc_reg, 32'd0);
    chk("sil20k_sq", {31'd0, dut.sq_reg}, 32'd0);
    run(512, 1'b1, 1'b1);
    tone = 32'd0;
    run(512, 1'b1, 1'b1);
    chk("sil0_sample", {16'd0, dut.sample_reg}, 32'd0);
    chk("sil0_acc", dut.acc_reg, 32'd0);

    // Just below SILENCE_MIN is audible: acc advances by 2*19999
    tone = 32'd19999;
    run(2, 1'b0, 1'b0);
    chk("t19999_acc", dut.acc_reg, 32'd39998);
    tone = 32'd0;
    run(2, 1'b0, 1'b0);
    chk("t19999_clear", dut.acc_reg, 32'd0);
    to_frame();

    // 1000 Hz: first toggle exactly 50000 clks after tone_r is valid
    tone = 32'd1000;
    run(512, 1'b0, 1'b0);
    chk("t1k_sample_lo", {16'd0, dut.sample_reg}, 32'h0000_C800);
    run(50000 - 512, 1'b0, 1'b0);
    chk("t1k_sq_pre", {31'd0, dut.sq_reg}, 32'd0);
    chk("t1k_acc_pre", dut.acc_reg, 32'd99_998_000);
    chk("t1k_sample_pre", {16'd0, dut.sample_reg}, 32'h0000_C800);
    run(1, 1'b0, 1'b0);
    chk("t1k_sq_toggle", {31'd0, dut.sq_reg}, 32'd1);
    chk("t1k_acc_wrap", dut.acc_reg, 32'd0);
    to_frame();
    chk("t1k_sample_hi", {16'd0, dut.sample_reg}, 32'h0000_3800);
    ser_frame("sdin_3800", bits_3800);

    // Reset during slot 9 of a right half (clk_cnt = 330)
    tone = 32'd523;
    run(330, 1'b1, 1'b0);
    chk("pre_rst_outs", {28'd0, audio_lrck, audio_sck, audio_mclk, audio_sdin}, 32'b1010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {28'd0, audio_lrck, audio_sck, audio_mclk, audio_sdin}, 32'd0);
    chk("mid_rst_sample", {16'd0, dut.sample_reg}, 32'd0);
    chk("mid_rst_acc", dut.acc_reg, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    run(511, 1'b1, 1'b1);
    chk("post_rst_sample0", {16'd0, dut.sample_reg}, 32'd0);
    run(1, 1'b1, 1'b1);
    chk("post_rst_sample", {16'd0, dut.sample_reg}, 32'h0000_C800);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
